// File: rtl/qqspi_cache_pkg.sv
`default_nettype none
// ============================================================================
// qqspi_cache_pkg : shared types and helpers for the qqspi read cache
// Rev 1.0
// ============================================================================
package qqspi_cache_pkg;

   typedef enum logic [2:0] {
      ST_INIT   = 3'd0,
      ST_IDLE   = 3'd1,
      ST_LOOKUP = 3'd2,
      ST_FILL   = 3'd3,
      ST_WRITE  = 3'd4,
      ST_DONE   = 3'd5
   } cache_state_e;

   function automatic int idx_w(input int lines);
      return $clog2(lines);
   endfunction

   // The target select is stored as the tag MSB so flash and PSRAM never alias.
   function automatic int tag_w(input int addr_w, input int lines);
      return 1 + addr_w - $clog2(lines);
   endfunction

   function automatic logic [31:0] byte_merge(input logic [31:0] old_data,
                                              input logic [31:0] new_data,
                                              input logic [3:0]  strb);
      logic [31:0] merged;
      merged = old_data;
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) merged[8*b +: 8] = new_data[8*b +: 8];
      end
      return merged;
   endfunction

endpackage
`default_nettype wire

// File: rtl/qqspi_cache_ram.sv
`default_nettype none
// ============================================================================
// qqspi_cache_ram : LINES x {valid, tag, data} single-port array, registered
// read, plus a per-line valid-clear port used while invalidating.  Rev 1.0
// ============================================================================
module qqspi_cache_ram
   import qqspi_cache_pkg::*;
#(
   parameter int LINES = 64,
   parameter int TAG_W = 18,
   parameter int IDX_W = idx_w(LINES)
) (
   input  logic             clk,
   input  logic             en_i,
   input  logic             we_i,
   input  logic [IDX_W-1:0] addr_i,
   input  logic [TAG_W-1:0] wtag_i,
   input  logic [31:0]      wdata_i,
   input  logic             clr_i,
   input  logic [IDX_W-1:0] clr_idx_i,
   output logic             rvalid_o,
   output logic [TAG_W-1:0] rtag_o,
   output logic [31:0]      rdata_o
);

   logic [TAG_W-1:0] tag_mem  [LINES];
   logic [31:0]      data_mem [LINES];
   logic [LINES-1:0] valid_q;

   logic             rvalid_q;
   logic [TAG_W-1:0] rtag_q;
   logic [31:0]      rdata_q;

   always_ff @(posedge clk) begin
      if (en_i && we_i) begin
         tag_mem[addr_i]  <= wtag_i;
         data_mem[addr_i] <= wdata_i;
      end
   end

   // Valid bits live in flops so a line can be cleared while the port is idle.
   always_ff @(posedge clk) begin
      if (clr_i)         valid_q[clr_idx_i] <= 1'b0;
      if (en_i && we_i)  valid_q[addr_i]    <= 1'b1;
   end

   always_ff @(posedge clk) begin
      if (en_i && !we_i) begin
         rvalid_q <= valid_q[addr_i];
         rtag_q   <= tag_mem[addr_i];
         rdata_q  <= data_mem[addr_i];
      end
   end

   assign rvalid_o = rvalid_q;
   assign rtag_o   = rtag_q;
   assign rdata_o  = rdata_q;

endmodule
`default_nettype wire

// File: rtl/qqspi_read_cache.sv
`default_nettype none
// ============================================================================
// qqspi_read_cache : direct-mapped, write-through, no-write-allocate cache in
// front of qqspi. Define QQSPI_CACHE_STATS_EN for hit/miss counters. Rev 1.0
// ============================================================================
module qqspi_read_cache
   import qqspi_cache_pkg::*;
#(
   parameter int LINES  = 64,
   parameter int ADDR_W = 23
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cpu_valid,
   output logic              cpu_ready,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic              cpu_sel,
   input  logic [3:0]        cpu_wstrb,
   input  logic [31:0]       cpu_wdata,
   output logic [31:0]       cpu_rdata,
   input  logic              flush,
   output logic              mem_valid,
   input  logic              mem_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_sel,
   output logic [3:0]        mem_wstrb,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   output logic [31:0]       hit_cnt,
   output logic [31:0]       miss_cnt
);

   localparam int IDX_W = idx_w(LINES);
   localparam int TAG_W = tag_w(ADDR_W, LINES);

   cache_state_e      state_q, state_d;
   logic [IDX_W-1:0]  init_idx_q, init_idx_d;
   logic              flush_pending_q, flush_pending_d;
   logic              mem_valid_q, mem_valid_d;
   logic [ADDR_W-1:0] req_addr_q, req_addr_d;
   logic              req_sel_q, req_sel_d;
   logic [3:0]        req_wstrb_q, req_wstrb_d;
   logic [31:0]       req_wdata_q, req_wdata_d;
   logic [31:0]       data_q, data_d;

   logic              w_ram_en;
   logic              w_ram_we;
   logic [IDX_W-1:0]  w_ram_addr;
   logic [31:0]       w_ram_wdata;
   logic              w_ram_clr;
   logic              w_ram_rvalid;
   logic [TAG_W-1:0]  w_ram_rtag;
   logic [31:0]       w_ram_rdata;
   logic [TAG_W-1:0]  w_req_tag;
   logic              w_hit;
   logic              w_is_write;

   qqspi_cache_ram #(
      .LINES (LINES),
      .TAG_W (TAG_W),
      .IDX_W (IDX_W)
   ) u_ram (
      .clk       (clk),
      .en_i      (w_ram_en),
      .we_i      (w_ram_we),
      .addr_i    (w_ram_addr),
      .wtag_i    (w_req_tag),
      .wdata_i   (w_ram_wdata),
      .clr_i     (w_ram_clr),
      .clr_idx_i (init_idx_q),
      .rvalid_o  (w_ram_rvalid),
      .rtag_o    (w_ram_rtag),
      .rdata_o   (w_ram_rdata)
   );

   assign w_req_tag  = {req_sel_q, req_addr_q[ADDR_W-1:IDX_W]};
   // The array is not re-read until the next IDLE, so the hit stays valid through WRITE.
   assign w_hit      = w_ram_rvalid && (w_ram_rtag == w_req_tag);
   assign w_is_write = |req_wstrb_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q         <= ST_INIT;
         init_idx_q      <= '0;
         flush_pending_q <= 1'b0;
         mem_valid_q     <= 1'b0;
      end else begin
         state_q         <= state_d;
         init_idx_q      <= init_idx_d;
         flush_pending_q <= flush_pending_d;
         mem_valid_q     <= mem_valid_d;
      end
   end

   always_ff @(posedge clk) begin
      req_addr_q  <= req_addr_d;
      req_sel_q   <= req_sel_d;
      req_wstrb_q <= req_wstrb_d;
      req_wdata_q <= req_wdata_d;
      data_q      <= data_d;
   end

   always_comb begin
      state_d     = state_q;
      init_idx_d  = init_idx_q;
      mem_valid_d = mem_valid_q;
      req_addr_d  = req_addr_q;
      req_sel_d   = req_sel_q;
      req_wstrb_d = req_wstrb_q;
      req_wdata_d = req_wdata_q;
      data_d      = data_q;
      w_ram_en    = 1'b0;
      w_ram_we    = 1'b0;
      w_ram_addr  = req_addr_q[IDX_W-1:0];
      w_ram_wdata = mem_rdata;
      w_ram_clr   = 1'b0;
      cpu_ready   = 1'b0;
      cpu_rdata   = 32'd0;

      case (state_q)
         ST_INIT: begin
            w_ram_clr = 1'b1;
            if (flush) begin
               init_idx_d = '0;
            end else if (init_idx_q == IDX_W'(LINES - 1)) begin
               init_idx_d = '0;
               state_d    = ST_IDLE;
            end else begin
               init_idx_d = init_idx_q + IDX_W'(1);
            end
         end

         ST_IDLE: begin
            if (flush_pending_q || flush) begin
               state_d = ST_INIT;
            end else if (cpu_valid) begin
               req_addr_d  = cpu_addr;
               req_sel_d   = cpu_sel;
               req_wstrb_d = cpu_wstrb;
               req_wdata_d = cpu_wdata;
               w_ram_en    = 1'b1;
               w_ram_addr  = cpu_addr[IDX_W-1:0];
               state_d     = ST_LOOKUP;
            end
         end

         ST_LOOKUP: begin
            if (w_is_write) begin
               data_d      = 32'd0;
               mem_valid_d = req_sel_q;
               state_d     = ST_WRITE;
            end else if (w_hit) begin
               cpu_ready = 1'b1;
               cpu_rdata = w_ram_rdata;
               state_d   = ST_IDLE;
            end else begin
               mem_valid_d = 1'b1;
               state_d     = ST_FILL;
            end
         end

         ST_FILL: begin
            if (mem_ready) begin
               w_ram_en    = 1'b1;
               w_ram_we    = 1'b1;
               data_d      = mem_rdata;
               mem_valid_d = 1'b0;
               state_d     = ST_DONE;
            end
         end

         ST_WRITE: begin
            if (!req_sel_q) begin
               state_d = ST_DONE;
            end else if (mem_ready) begin
               mem_valid_d = 1'b0;
               state_d     = ST_DONE;
               if (w_hit) begin
                  w_ram_en    = 1'b1;
                  w_ram_we    = 1'b1;
                  w_ram_wdata = byte_merge(w_ram_rdata, req_wdata_q, req_wstrb_q);
               end
            end
         end

         ST_DONE: begin
            cpu_ready = 1'b1;
            cpu_rdata = data_q;
            state_d   = ST_IDLE;
         end

         default: begin
            state_d = ST_INIT;
         end
      endcase

      // Entering INIT consumes the pending flush; INIT handles its own restarts.
      flush_pending_d = (state_q != ST_INIT && state_d != ST_INIT) ?
                        (flush_pending_q | flush) : 1'b0;
   end

   assign mem_valid = mem_valid_q;
   assign mem_addr  = req_addr_q;
   assign mem_sel   = req_sel_q;
   assign mem_wdata = req_wdata_q;
   assign mem_wstrb = (mem_valid_q && state_q == ST_WRITE) ? req_wstrb_q : 4'd0;

`ifdef QQSPI_CACHE_STATS_EN
   logic [31:0] hit_cnt_q;
   logic [31:0] miss_cnt_q;
   logic        w_lookup_rd;

   assign w_lookup_rd = (state_q == ST_LOOKUP) && !w_is_write;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hit_cnt_q  <= 32'd0;
         miss_cnt_q <= 32'd0;
      end else begin
         if (w_lookup_rd && w_hit)  hit_cnt_q  <= hit_cnt_q + 32'd1;
         if (w_lookup_rd && !w_hit) miss_cnt_q <= miss_cnt_q + 32'd1;
      end
   end

   assign hit_cnt  = hit_cnt_q;
   assign miss_cnt = miss_cnt_q;
`else
   assign hit_cnt  = 32'd0;
   assign miss_cnt = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_qqspi_read_cache.sv
`default_nettype none
// ============================================================================
// tb_qqspi_read_cache : directed table-driven bench with a qqspi memory model
// Rev 1.0
// ============================================================================
module tb_qqspi_read_cache;

   localparam int MEM_LAT = 3;

   logic        clk;
   logic        rst_n;
   logic        cpu_valid;
   logic        cpu_ready;
   logic [22:0] cpu_addr;
   logic        cpu_sel;
   logic [3:0]  cpu_wstrb;
   logic [31:0] cpu_wdata;
   logic [31:0] cpu_rdata;
   logic        flush;
   logic        mem_valid;
   logic        mem_ready;
   logic [22:0] mem_addr;
   logic        mem_sel;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic [31:0] hit_cnt;
   logic [31:0] miss_cnt;

   qqspi_read_cache #(.LINES(64), .ADDR_W(23)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cpu_valid (cpu_valid),
      .cpu_ready (cpu_ready),
      .cpu_addr  (cpu_addr),
      .cpu_sel   (cpu_sel),
      .cpu_wstrb (cpu_wstrb),
      .cpu_wdata (cpu_wdata),
      .cpu_rdata (cpu_rdata),
      .flush     (flush),
      .mem_valid (mem_valid),
      .mem_ready (mem_ready),
      .mem_addr  (mem_addr),
      .mem_sel   (mem_sel),
      .mem_wstrb (mem_wstrb),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .hit_cnt   (hit_cnt),
      .miss_cnt  (miss_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // ---------------- qqspi memory model ----------------
   logic [31:0] mem_model [logic [23:0]];
   int          mem_txn    = 0;
   int          stab_viol  = 0;
   logic [22:0] last_addr;
   logic        last_sel;
   logic [3:0]  last_wstrb;
   logic [31:0] last_wdata;

   function automatic logic [31:0] model_rd(input logic [23:0] key);
      if (mem_model.exists(key)) return mem_model[key];
      return {(key[23] ? 8'hC0 : 8'hF0), 1'b0, key[22:0]};
   endfunction

   function automatic logic [31:0] tb_merge(input logic [31:0] o, input logic [31:0] n,
                                            input logic [3:0] s);
      return {s[3] ? n[31:24] : o[31:24], s[2] ? n[23:16] : o[23:16],
              s[1] ? n[15:8]  : o[15:8],  s[0] ? n[7:0]   : o[7:0]};
   endfunction

   initial begin
      int          wcnt;
      logic [23:0] key;
      logic [22:0] s_addr;
      logic        s_sel;
      logic [3:0]  s_wstrb;
      logic [31:0] s_wdata;
      wcnt = 0;
      mem_ready = 1'b0;
      mem_rdata = 32'd0;
      forever begin
         @(posedge clk);
         #1;
         if (!rst_n) begin
            mem_ready = 1'b0;
            wcnt = 0;
         end else if (mem_ready) begin
            mem_ready = 1'b0;
         end else if (mem_valid) begin
            if (wcnt == 0) begin
               s_addr = mem_addr; s_sel = mem_sel; s_wstrb = mem_wstrb; s_wdata = mem_wdata;
            end else if (mem_addr !== s_addr || mem_sel !== s_sel ||
                         mem_wstrb !== s_wstrb || mem_wdata !== s_wdata) begin
               stab_viol++;
            end
            wcnt++;
            if (wcnt == MEM_LAT) begin
               key = {mem_sel, mem_addr};
               if (mem_wstrb != 4'd0) mem_model[key] = tb_merge(model_rd(key), mem_wdata, mem_wstrb);
               else                   mem_rdata = model_rd(key);
               last_addr = mem_addr; last_sel = mem_sel;
               last_wstrb = mem_wstrb; last_wdata = mem_wdata;
               mem_txn++;
               mem_ready = 1'b1;
               wcnt = 0;
            end
         end
      end
   end

   // ---------------- CPU request ----------------
   task automatic do_req(input logic sel, input logic [22:0] addr, input logic [3:0] wstrb,
                         input logic [31:0] wdata, output logic [31:0] rdata, output int lat);
      int n;
      cpu_valid = 1'b1; cpu_sel = sel; cpu_addr = addr; cpu_wstrb = wstrb; cpu_wdata = wdata;
      lat = -1; rdata = 32'd0; n = 0;
      while (lat < 0 && n < 300) begin
         @(posedge clk);
         #1;
         n++;
         if (cpu_ready) begin
            rdata = cpu_rdata;
            @(posedge clk);
            lat = n + 1;
            #1;
         end
      end
      cpu_valid = 1'b0; cpu_wstrb = 4'd0;
      if (lat < 0) begin
         n_chk++; n_err++;
         $display("FAIL req_timeout: got no cpu_ready, expected one within 300 cycles");
      end
   endtask

   typedef struct {
      logic        sel;
      logic [22:0] addr;
      logic [3:0]  wstrb;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      int          exp_lat;
      int          exp_txn;
      logic [3:0]  exp_mwstrb;
   } vec_t;

   vec_t        vecs [17];
   logic [31:0] rd;
   int          lat;
   int          txn0;
   logic        injected;
   logic        seen;
   logic [31:0] exp_hits;
   logic [31:0] exp_miss;

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish, expected end of test");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; cpu_valid = 1'b0; cpu_addr = '0; cpu_sel = 1'b0;
      cpu_wstrb = 4'd0; cpu_wdata = 32'd0; flush = 1'b0;
      mem_model[{1'b1, 23'h20}] = 32'h11223344;

      vecs[0]  = '{1'b1, 23'h10,     4'h0, 32'h0,        32'hC0000010, 2, 0, 4'h0};
      vecs[1]  = '{1'b1, 23'h50,     4'h0, 32'h0,        32'hC0000050, 6, 1, 4'h0};
      vecs[2]  = '{1'b1, 23'h10,     4'h0, 32'h0,        32'hC0000010, 6, 1, 4'h0};
      vecs[3]  = '{1'b0, 23'h10,     4'h0, 32'h0,        32'hF0000010, 6, 1, 4'h0};
      vecs[4]  = '{1'b1, 23'h10,     4'h0, 32'h0,        32'hC0000010, 6, 1, 4'h0};
      vecs[5]  = '{1'b1, 23'h20,     4'h0, 32'h0,        32'h11223344, 6, 1, 4'h0};
      vecs[6]  = '{1'b1, 23'h20,     4'h0, 32'h0,        32'h11223344, 2, 0, 4'h0};
      vecs[7]  = '{1'b1, 23'h20,     4'h2, 32'hAABBCCDD, 32'h00000000, 6, 1, 4'h2};
      vecs[8]  = '{1'b1, 23'h20,     4'h0, 32'h0,        32'h1122CC44, 2, 0, 4'h0};
      vecs[9]  = '{1'b0, 23'h30,     4'hF, 32'hDEADBEEF, 32'h00000000, 4, 0, 4'h0};
      vecs[10] = '{1'b0, 23'h30,     4'h0, 32'h0,        32'hF0000030, 6, 1, 4'h0};
      vecs[11] = '{1'b1, 23'h60,     4'hF, 32'h12345678, 32'h00000000, 6, 1, 4'hF};
      vecs[12] = '{1'b1, 23'h20,     4'h0, 32'h0,        32'h1122CC44, 2, 0, 4'h0};
      vecs[13] = '{1'b1, 23'h60,     4'h0, 32'h0,        32'h12345678, 6, 1, 4'h0};
      vecs[14] = '{1'b1, 23'h7FFFFF, 4'h0, 32'h0,        32'hC07FFFFF, 6, 1, 4'h0};
      vecs[15] = '{1'b1, 23'h7FFFFF, 4'h0, 32'h0,        32'hC07FFFFF, 2, 0, 4'h0};
      vecs[16] = '{1'b1, 23'h3F,     4'h0, 32'h0,        32'hC000003F, 6, 1, 4'h0};

      repeat (3) @(posedge clk);
      #1;
      chk("rst_cpu_ready", 32'(cpu_ready), 32'd0);
      chk("rst_mem_valid", 32'(mem_valid), 32'd0);
      chk("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
      chk("rst_hit_cnt", hit_cnt, 32'd0);
      chk("rst_miss_cnt", miss_cnt, 32'd0);

      // Request raised together with reset release: held off for the full INIT sweep.
      rst_n = 1'b1;
      txn0 = mem_txn;
      do_req(1'b1, 23'h10, 4'h0, 32'h0, rd, lat);
      chk("init_rdata", rd, 32'hC0000010);
      chk("init_lat", 32'(lat), 32'd70);
      chk("init_txn", 32'(mem_txn - txn0), 32'd1);
      chk("init_fill_wstrb", 32'(last_wstrb), 32'd0);

      for (int i = 0; i < 17; i++) begin
         txn0 = mem_txn;
         do_req(vecs[i].sel, vecs[i].addr, vecs[i].wstrb, vecs[i].wdata, rd, lat);
         chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
         chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
         chk($sformatf("v%0d_txn", i), 32'(mem_txn - txn0), 32'(vecs[i].exp_txn));
         if (vecs[i].exp_txn == 1) begin
            chk($sformatf("v%0d_maddr", i), 32'(last_addr), 32'(vecs[i].addr));
            chk($sformatf("v%0d_msel", i), 32'(last_sel), 32'(vecs[i].sel));
            chk($sformatf("v%0d_mwstrb", i), 32'(last_wstrb), 32'(vecs[i].exp_mwstrb));
            if (vecs[i].exp_mwstrb != 4'd0)
               chk($sformatf("v%0d_mwdata", i), last_wdata, vecs[i].wdata);
         end
      end

      // Flush during FILL: the fill completes, then INIT runs before the next lookup.
      injected = 1'b0;
      txn0 = mem_txn;
      fork
         do_req(1'b1, 23'h100, 4'h0, 32'h0, rd, lat);
         begin
            for (int n = 0; n < 50 && !injected; n++) begin
               @(posedge clk);
               #1;
               if (mem_valid) begin
                  flush = 1'b1;
                  @(posedge clk);
                  #1;
                  flush = 1'b0;
                  injected = 1'b1;
               end
            end
         end
      join
      chk("flush_injected", 32'(injected), 32'd1);
      chk("flush_fill_rdata", rd, 32'hC0000100);
      chk("flush_fill_lat", 32'(lat), 32'd6);
      chk("flush_fill_txn", 32'(mem_txn - txn0), 32'd1);

      txn0 = mem_txn;
      do_req(1'b1, 23'h100, 4'h0, 32'h0, rd, lat);
      chk("post_flush_rdata", rd, 32'hC0000100);
      chk("post_flush_lat", 32'(lat), 32'd71);
      chk("post_flush_txn", 32'(mem_txn - txn0), 32'd1);

      // A second flush 10 cycles into INIT restarts the sweep at index 0.
      txn0 = mem_txn;
      fork
         do_req(1'b1, 23'h10, 4'h0, 32'h0, rd, lat);
         begin
            flush = 1'b1;
            @(posedge clk);
            #1;
            flush = 1'b0;
            repeat (10) @(posedge clk);
            #1;
            flush = 1'b1;
            @(posedge clk);
            #1;
            flush = 1'b0;
         end
      join
      chk("restart_rdata", rd, 32'hC0000010);
      chk("restart_lat", 32'(lat), 32'd82);
      chk("restart_txn", 32'(mem_txn - txn0), 32'd1);

`ifdef QQSPI_CACHE_STATS_EN
      exp_hits = 32'd5;
      exp_miss = 32'd13;
`else
      exp_hits = 32'd0;
      exp_miss = 32'd0;
`endif
      chk("hit_cnt", hit_cnt, exp_hits);
      chk("miss_cnt", miss_cnt, exp_miss);
      chk("mem_stable", 32'(stab_viol), 32'd0);

      // Reset while a fill is outstanding.
      cpu_valid = 1'b1; cpu_sel = 1'b1; cpu_addr = 23'h200; cpu_wstrb = 4'd0;
      seen = 1'b0;
      for (int n = 0; n < 20 && !seen; n++) begin
         @(posedge clk);
         #1;
         if (mem_valid) seen = 1'b1;
      end
      chk("rst_fill_reached", 32'(seen), 32'd1);
      rst_n = 1'b0;
      cpu_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_fill_mem_valid", 32'(mem_valid), 32'd0);
      chk("rst_fill_cpu_ready", 32'(cpu_ready), 32'd0);
      chk("rst_fill_mem_wstrb", 32'(mem_wstrb), 32'd0);
      chk("rst_fill_hit_cnt", hit_cnt, 32'd0);
      chk("rst_fill_miss_cnt", miss_cnt, 32'd0);
      rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("rst_fill_no_replay", 32'(mem_valid), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
